step_motor_arbiter: RTL and testbench

STEP_MOTOR_ARBITER -- requirements
Module: step_motor_arbiter

---
 rtl/step_motor_arbiter.sv | 173 +++++++++++++++++
 tb/tb_step_motor_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_motor_arbiter.sv
// Stepper-motor arbiter: grants one of two move requesters (bomb alarm, timer
// tick) exclusive use of a shared stepper, sequences the coil phase table for
// the requested number of steps, and pulses done on completion.
// Alarm wins ties, except that after two alarm grants made while tick_req was
// waiting, the next tie goes to tick.
// Optional build macro: STEP_MOTOR_HALF_STEP_EN selects the 8-entry half-step
// table; without it the 4-entry full-step table is used.
module step_motor_arbiter #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_req,
  input  logic [3:0] alarm_steps,
  input  logic       tick_req,
  input  logic [3:0] tick_steps,
  input  logic       mute,
  output logic       alarm_gnt,
  output logic       tick_gnt,
  output logic       done,
  output logic [3:0] stepout
);

`ifdef STEP_MOTOR_HALF_STEP_EN
  localparam int unsigned PTR_W = 3;
`else
  localparam int unsigned PTR_W = 2;
`endif
  localparam int unsigned PRE_W   = 16;
  localparam int unsigned STEPS_W = 4;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PRE_W-1:0]     presc_q;
  logic [STEPS_W-1:0]   rem_q;
  logic [1:0]           starve_q;
  logic                 arm_q;
  logic                 alarm_gnt_q;
  logic                 tick_gnt_q;
  logic                 done_q;
  logic [3:0]           stepout_q;

  logic                 any_req_c;
  logic                 pick_tick_c;
  logic [STEPS_W-1:0]   grant_steps_c;
  logic [PTR_W-1:0]     ptr_inc_c;
  logic [PTR_W-1:0]     ptr_dec_c;
  logic [PTR_W-1:0]     grant_ptr_c;
  logic [PTR_W-1:0]     run_ptr_c;

  // Coil pattern for a phase pointer value.
  function automatic logic [3:0] phase_pattern(input logic [PTR_W-1:0] p);
    logic [3:0] pat;
    pat = 4'b0000;
`ifdef STEP_MOTOR_HALF_STEP_EN
    case (p)
      3'd0: pat = 4'b1000;
      3'd1: pat = 4'b1100;
      3'd2: pat = 4'b0100;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0010;
      3'd5: pat = 4'b0011;
      3'd6: pat = 4'b0001;
      3'd7: pat = 4'b1001;
    endcase
`else
    case (p)
      2'd0: pat = 4'b1000;
      2'd1: pat = 4'b0100;
      2'd2: pat = 4'b0010;
      2'd3: pat = 4'b0001;
    endcase
`endif
    return pat;
  endfunction

  // Arbitration choice and phase pointer neighbours (pointer wraps naturally).
  assign any_req_c     = alarm_req | tick_req;
  assign pick_tick_c   = tick_req & (~alarm_req | (starve_q == 2'd2));
  assign grant_steps_c = pick_tick_c ? tick_steps : alarm_steps;
  assign ptr_inc_c     = ptr_q + PTR_W'(1);
  assign ptr_dec_c     = ptr_q - PTR_W'(1);
  assign grant_ptr_c   = pick_tick_c ? ptr_dec_c : ptr_inc_c;
  assign run_ptr_c     = alarm_gnt_q ? ptr_inc_c : ptr_dec_c;

  // Arbiter/sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      presc_q     <= '0;
      rem_q       <= '0;
      starve_q    <= 2'd0;
      arm_q       <= 1'b0;
      alarm_gnt_q <= 1'b0;
      tick_gnt_q  <= 1'b0;
      done_q      <= 1'b0;
      stepout_q   <= 4'b0000;
    end else begin
      arm_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (arm_q && !mute && any_req_c) begin
            if (pick_tick_c) begin
              tick_gnt_q <= 1'b1;
              starve_q   <= 2'd0;
            end else begin
              alarm_gnt_q <= 1'b1;
              starve_q    <= tick_req ? (starve_q + 2'd1) : 2'd0;
            end
            if (grant_steps_c == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              rem_q     <= grant_steps_c;
              presc_q   <= '0;
              ptr_q     <= grant_ptr_c;
              stepout_q <= phase_pattern(grant_ptr_c);
            end
          end
        end
        S_RUN: begin
          if (mute) begin
            stepout_q <= 4'b0000;
          end else if (presc_q == PRE_LAST) begin
            presc_q <= '0;
            if (rem_q == STEPS_W'(1)) begin
              rem_q     <= '0;
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              stepout_q <= 4'b0000;
            end else begin
              rem_q     <= rem_q - STEPS_W'(1);
              ptr_q     <= run_ptr_c;
              stepout_q <= phase_pattern(run_ptr_c);
            end
          end else begin
            presc_q   <= presc_q + PRE_W'(1);
            stepout_q <= phase_pattern(ptr_q);
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          alarm_gnt_q <= 1'b0;
          tick_gnt_q  <= 1'b0;
          stepout_q   <= 4'b0000;
        end
        default: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          alarm_gnt_q <= 1'b0;
          tick_gnt_q  <= 1'b0;
          stepout_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign alarm_gnt = alarm_gnt_q;
  assign tick_gnt  = tick_gnt_q;
  assign done      = done_q;
  assign stepout   = stepout_q;

endmodule

// File: tb/tb_step_motor_arbiter.sv
// Bench for step_motor_arbiter: a model-timed driver issues moves and pushes
// the expected move record (owner, duration, energised cycles, pattern order)
// onto a scoreboard; a negedge monitor rebuilds each move from the DUT pins
// and compares when done pulses.
module tb_step_motor_arbiter;

  localparam int D = 4;
`ifdef STEP_MOTOR_HALF_STEP_EN
  localparam int PL = 8;
`else
  localparam int PL = 4;
`endif

  logic       clk;
  logic       rst;
  logic       alarm_req;
  logic [3:0] alarm_steps;
  logic       tick_req;
  logic [3:0] tick_steps;
  logic       mute;
  logic       alarm_gnt;
  logic       tick_gnt;
  logic       done;
  logic [3:0] stepout;

  typedef struct {
    bit          owner_alarm;
    int          cyc;
    int          nz;
    logic [63:0] sig;
  } exp_t;

  exp_t sbq[$];
  int   total;
  int   bad;
  int   mptr;
  int   starve;
  bit   a_pend;
  bit   t_pend;

  step_motor_arbiter #(.STEP_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .alarm_req  (alarm_req),
    .alarm_steps(alarm_steps),
    .tick_req   (tick_req),
    .tick_steps (tick_steps),
    .mute       (mute),
    .alarm_gnt  (alarm_gnt),
    .tick_gnt   (tick_gnt),
    .done       (done),
    .stepout    (stepout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase table as the reference sees it.
  function automatic logic [3:0] model_pat(input int p);
    logic [3:0] half_tbl [8];
    logic [3:0] full;
    half_tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    full = 4'b1000 >> p;
    return (PL == 8) ? half_tbl[p] : full;
  endfunction

  // Issue one move from an armed IDLE negedge; returns at the next IDLE negedge.
  task automatic run_move(input bit a_new, input bit t_new,
                          input logic [3:0] as, input logic [3:0] ts,
                          input int mk, input int mm, input int im, input bit keep);
    bit   win_a;
    int   n, m, k, len;
    exp_t e;
    if (a_new) begin alarm_req = 1'b1; a_pend = 1'b1; end
    if (t_new) begin tick_req = 1'b1; t_pend = 1'b1; end
    alarm_steps = as;
    tick_steps  = ts;
    if (im > 0) begin
      mute = 1'b1;
      repeat (im) @(negedge clk);
      mute = 1'b0;
    end
    win_a = a_pend && !(t_pend && starve >= 2);
    if (win_a) starve = t_pend ? starve + 1 : 0;
    else       starve = 0;
    n = win_a ? int'(as) : int'(ts);
    m = (n == 0) ? 0 : mm;
    k = (n == 0) ? 0 : 1 + (mk % (n * D));
    e.sig = 64'd0;
    for (int i = 0; i < n; i++) begin
      mptr  = win_a ? (mptr + 1) % PL : (mptr + PL - 1) % PL;
      e.sig = {e.sig[59:0], model_pat(mptr)};
    end
    e.owner_alarm = win_a;
    e.cyc = n * D + m + 1;
    e.nz  = n * D;
    sbq.push_back(e);
    len = n * D + m;
    for (int ed = 1; ed <= len; ed++) begin
      @(negedge clk);
      mute = (m > 0 && ed >= k && ed < k + m);
    end
    @(negedge clk);
    mute = 1'b0;
    if (!keep) begin
      if (win_a) begin alarm_req = 1'b0; a_pend = 1'b0; end
      else       begin tick_req  = 1'b0; t_pend = 1'b0; end
    end
    @(negedge clk);
  endtask

  // Monitor: rebuild each move from the pins and score it on done.
  initial begin
    bit          active;
    bit          own;
    int          cyc;
    int          nz;
    logic [63:0] sig;
    logic [3:0]  last;
    exp_t        e;
    active = 1'b0;
    own = 1'b0; cyc = 0; nz = 0; sig = 64'd0; last = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 1'b0;
      end else begin
        chk("gnt_exclusive", 64'(alarm_gnt & tick_gnt), 64'd0);
        if (!active && (alarm_gnt || tick_gnt)) begin
          active = 1'b1; own = alarm_gnt; cyc = 0; nz = 0; sig = 64'd0; last = 4'd0;
        end
        if (active) begin
          cyc++;
          chk("owner_held", 64'({alarm_gnt, tick_gnt}), own ? 64'd2 : 64'd1);
          if (stepout != 4'd0) begin
            nz++;
            if (stepout != last) begin
              sig  = {sig[59:0], stepout};
              last = stepout;
            end
          end
          if (done) begin
            chk("done_stepout", 64'(stepout), 64'd0);
            if (sbq.size() == 0) begin
              chk("unexpected_move", 64'd1, 64'd0);
            end else begin
              e = sbq.pop_front();
              chk("move_owner", 64'(own), 64'(e.owner_alarm));
              chk("move_cycles", 64'(cyc), 64'(e.cyc));
              chk("move_energised", 64'(nz), 64'(e.nz));
              chk("move_patterns", sig, e.sig);
            end
            active = 1'b0;
          end
        end else begin
          chk("idle_quiet", 64'({done, stepout}), 64'd0);
        end
      end
    end
  end

  // Driver: directed scenarios, randomized rounds, then mid-move reset.
  initial begin
    bit an, tn;
    int n_max;
    total = 0; bad = 0; mptr = 0; starve = 0; a_pend = 1'b0; t_pend = 1'b0;
    rst = 1'b1; alarm_req = 1'b0; tick_req = 1'b0; mute = 1'b0;
    alarm_steps = 4'd0; tick_steps = 4'd0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_alarm_gnt", 64'(alarm_gnt), 64'd0);
    chk("reset_tick_gnt", 64'(tick_gnt), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_stepout", 64'(stepout), 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

`ifdef STEP_MOTOR_HALF_STEP_EN
    run_move(1'b1, 1'b0, 4'd2, 4'd0, 0, 0, 0, 1'b0);
`endif
    run_move(1'b0, 1'b1, 4'd0, 4'd3, 0, 0, 0, 1'b0);
    run_move(1'b1, 1'b1, 4'd1, 4'd2, 0, 0, 0, 1'b0);
    run_move(1'b0, 1'b0, 4'd1, 4'd2, 0, 0, 0, 1'b0);
    run_move(1'b1, 1'b1, 4'd1, 4'd1, 0, 0, 0, 1'b1);
    run_move(1'b0, 1'b0, 4'd2, 4'd1, 0, 0, 0, 1'b1);
    run_move(1'b0, 1'b0, 4'd1, 4'd3, 0, 0, 0, 1'b0);
    run_move(1'b0, 1'b0, 4'd1, 4'd1, 0, 0, 0, 1'b0);
    run_move(1'b1, 1'b0, 4'd3, 4'd0, 4, 10, 0, 1'b0);
    run_move(1'b1, 1'b0, 4'd0, 4'd0, 0, 0, 0, 1'b0);
    run_move(1'b0, 1'b1, 4'd0, 4'd2, 0, 0, 5, 1'b0);
    run_move(1'b1, 1'b1, 4'd15, 4'd0, 0, 0, 0, 1'b0);
    run_move(1'b0, 1'b0, 4'd0, 4'd0, 0, 0, 0, 1'b0);

    for (int r = 0; r < 200; r++) begin
      an = !a_pend && ($urandom_range(0, 1) == 1);
      tn = !t_pend && ($urandom_range(0, 1) == 1);
      if (!a_pend && !t_pend && !an && !tn) begin
        if ($urandom_range(0, 1) == 1) an = 1'b1;
        else tn = 1'b1;
      end
      n_max = ($urandom_range(0, 3) == 0) ? 15 : 4;
      run_move(an, tn, 4'($urandom_range(0, n_max)), 4'($urandom_range(0, n_max)),
               int'($urandom_range(0, 60)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0,
               ($urandom_range(0, 3) == 0));
    end
    while (a_pend || t_pend) run_move(1'b0, 1'b0, 4'd1, 4'd1, 0, 0, 0, 1'b0);

    alarm_req = 1'b0; tick_req = 1'b1; tick_steps = 4'd5; alarm_steps = 4'd0;
    repeat (3) @(negedge clk);
    chk("pre_reset_stepout_live", 64'(stepout != 4'd0), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("midreset_alarm_gnt", 64'(alarm_gnt), 64'd0);
    chk("midreset_tick_gnt", 64'(tick_gnt), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_stepout", 64'(stepout), 64'd0);
    sbq.delete();
    mptr = 0; starve = 0; t_pend = 1'b1; a_pend = 1'b0; tick_steps = 4'd1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("no_grant_first_edge", 64'({alarm_gnt, tick_gnt}), 64'd0);
    run_move(1'b0, 1'b0, 4'd0, 4'd1, 0, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
